// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART_N receiver / core logic and the receive FIFO.
interface uart_rx_fifo_if #(
  parameter int word_width = 8,
  parameter int depth_log2 = 4
);
  logic                  R_locked;
  logic [word_width-1:0] R_W;
  logic                  read;
  logic                  clear_ovf;
  logic [word_width-1:0] D_OUT;
  logic                  empty;
  logic                  full;
  logic [depth_log2:0]   count;
  logic                  overflow;

  modport master (
    output R_locked, R_W, read, clear_ovf,
    input  D_OUT, empty, full, count, overflow
  );

  modport slave (
    input  R_locked, R_W, read, clear_ovf,
    output D_OUT, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind UART_N: queues each word on the falling edge of R_locked,
// first-word-fall-through read port, sticky overflow when a word is dropped.
module uart_rx_fifo #(
  parameter int word_width = 8,
  parameter int depth_log2 = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << depth_log2;
  localparam logic [depth_log2:0]   CNT_ONE  = (depth_log2+1)'(1);
  localparam logic [depth_log2:0]   CNT_FULL = (depth_log2+1)'(DEPTH);
  localparam logic [depth_log2-1:0] PTR_ONE  = depth_log2'(1);

  logic [word_width-1:0] r_mem [DEPTH];
  logic [depth_log2-1:0] r_wr_ptr, r_rd_ptr;
  logic [depth_log2:0]   r_count;
  logic [word_width-1:0] r_dout;
  logic                  r_ovf, r_prev_locked, r_armed;

  logic                  w_empty, w_full, w_capture, w_pop, w_push;
  logic [depth_log2-1:0] w_rd_next;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  // r_armed blocks the partial frame that was in flight when reset released
  assign w_capture = r_prev_locked & ~bus.R_locked & r_armed;
  assign w_pop     = bus.read & ~w_empty;
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_rd_next = r_rd_ptr + PTR_ONE;

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= bus.R_W;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_dout        <= '0;
      r_ovf         <= 1'b0;
      r_prev_locked <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_prev_locked <= bus.R_locked;
      if (!bus.R_locked) r_armed <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= w_rd_next;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // Head register: a single remaining word being popped alongside a push
      // hands over straight from R_W, since memory has not been written yet.
      if (w_pop) begin
        if (r_count != CNT_ONE) r_dout <= r_mem[w_rd_next];
        else if (w_push)        r_dout <= bus.R_W;
      end else if (w_push && w_empty) begin
        r_dout <= bus.R_W;
      end
      if (w_capture && !w_push) r_ovf <= 1'b1;
      else if (bus.clear_ovf)   r_ovf <= 1'b0;
    end
  end

  assign bus.D_OUT    = r_dout;
  assign bus.empty    = w_empty;
  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_rx_fifo_if #(.word_width(8), .depth_log2(4)) bus ();
  uart_rx_fifo #(.word_width(8), .depth_log2(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_prev, m_armed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit cap, pop, push;
    if (reset) begin
      q.delete();
      m_dout = 8'h00; m_ovf = 0; m_prev = 0; m_armed = 0;
    end else begin
      cap  = m_prev && !bus.R_locked && m_armed;
      pop  = bus.read && (q.size() > 0);
      push = cap && ((q.size() < 16) || pop);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(bus.R_W);
      if (cap && !push)       m_ovf = 1;
      else if (bus.clear_ovf) m_ovf = 0;
      m_prev = bus.R_locked;
      if (!bus.R_locked) m_armed = 1;
      if (q.size() > 0) m_dout = q[0];
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".empty"},    32'(bus.empty),    32'(q.size() == 0));
    check({tag, ".full"},     32'(bus.full),     32'(q.size() == 16));
    check({tag, ".count"},    32'(bus.count),    32'(q.size()));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    check({tag, ".dout"},     32'(bus.D_OUT),    32'(m_dout));
  endtask

  // inputs are applied 1ns after a rising edge; model consumes them, edge fires, outputs compared
  task automatic tick(input string tag);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    bus.R_locked = 0; bus.read = 0; bus.clear_ovf = 0; reset = 0;
    tick(tag);
  endtask

  task automatic do_reset(input bit locked);
    reset = 1; bus.R_locked = locked; bus.read = 0; bus.clear_ovf = 0;
    tick("reset");
    reset = 0;
  endtask

  // one UART frame: busy for a few cycles with junk on R_W, then fall with word w
  task automatic frame(input logic [7:0] w, input bit rd, input bit clr, input string tag);
    bus.read = 0; bus.clear_ovf = 0;
    for (int k = 0; k < 3; k++) begin
      bus.R_locked = 1; bus.R_W = 8'($urandom);
      tick(tag);
    end
    bus.R_locked = 0; bus.R_W = w; bus.read = rd; bus.clear_ovf = clr;
    tick(tag);
    bus.read = 0; bus.clear_ovf = 0; bus.R_W = 8'($urandom);
  endtask

  task automatic pop1(input string tag);
    bus.R_locked = 0; bus.read = 1; bus.clear_ovf = 0;
    tick(tag);
    bus.read = 0;
  endtask

  initial begin
    bus.R_locked = 0; bus.R_W = 8'h00; bus.read = 0; bus.clear_ovf = 0; reset = 0;
    @(posedge clk); #1;

    // 1: basic capture and pop
    do_reset(0);
    check("t1.rst_empty", 32'(bus.empty), 32'd1);
    check("t1.rst_dout",  32'(bus.D_OUT), 32'h00);
    idle("t1.arm");
    frame(8'hA5, 0, 0, "t1.frame");
    check("t1.dout",  32'(bus.D_OUT), 32'hA5);
    check("t1.count", 32'(bus.count), 32'd1);
    pop1("t1.pop");
    check("t1.empty", 32'(bus.empty), 32'd1);

    // 2: reset released mid-frame must not capture the partial word
    do_reset(1);
    bus.R_W = 8'h3C;
    for (int k = 0; k < 3; k++) begin bus.R_locked = 1; tick("t2.busy"); end
    bus.R_locked = 0; tick("t2.fall");
    check("t2.no_cap", 32'(bus.empty), 32'd1);
    frame(8'h11, 0, 0, "t2.frame");
    check("t2.dout",  32'(bus.D_OUT), 32'h11);
    check("t2.count", 32'(bus.count), 32'd1);

    // 3: fill, overflow drop, ordered drain, clear
    do_reset(0); idle("t3.arm");
    for (int i = 0; i < 16; i++) frame(8'(i), 0, 0, "t3.fill");
    check("t3.full",  32'(bus.full),  32'd1);
    check("t3.count", 32'(bus.count), 32'd16);
    frame(8'hFF, 0, 0, "t3.drop");
    check("t3.ovf",   32'(bus.overflow), 32'd1);
    check("t3.count2", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t3.order", 32'(bus.D_OUT), 32'(i));
      pop1("t3.drain");
    end
    bus.clear_ovf = 1; tick("t3.clr"); bus.clear_ovf = 0;
    check("t3.ovf_clr", 32'(bus.overflow), 32'd0);

    // 4: full FIFO, capture and pop in same cycle
    for (int i = 0; i < 16; i++) frame(8'(i), 0, 0, "t4.fill");
    frame(8'h77, 1, 0, "t4.both");
    check("t4.dout",  32'(bus.D_OUT), 32'h01);
    check("t4.count", 32'(bus.count), 32'd16);
    check("t4.ovf",   32'(bus.overflow), 32'd0);
    for (int i = 0; i < 15; i++) pop1("t4.drain");
    check("t4.last", 32'(bus.D_OUT), 32'h77);
    pop1("t4.final");

    // 5: alternate push/pop across pointer wrap
    do_reset(0); idle("t5.arm");
    for (int i = 0; i < 40; i++) begin
      frame(8'(i), 0, 0, "t5.push");
      check("t5.dout", 32'(bus.D_OUT), 32'(i));
      check("t5.cnt_le1", 32'(bus.count <= 1), 32'd1);
      pop1("t5.pop");
    end
    check("t5.ovf", 32'(bus.overflow), 32'd0);

    // 6: read on empty with capture; overflow set beats clear
    frame(8'h5A, 1, 0, "t6.cap_rd");
    check("t6.count", 32'(bus.count), 32'd1);
    check("t6.dout",  32'(bus.D_OUT), 32'h5A);
    for (int i = 0; i < 15; i++) frame(8'($urandom), 0, 0, "t6.fill");
    frame(8'hEE, 0, 1, "t6.set_clr");
    check("t6.ovf", 32'(bus.overflow), 32'd1);
    pop1("t6.rd_empty_prep");

    // random traffic, including occasional reset
    for (int n = 0; n < 1500; n++) begin
      reset         = ($urandom_range(0, 99) < 2);
      bus.R_locked  = ($urandom_range(0, 99) < 55);
      bus.R_W       = 8'($urandom);
      bus.read      = ($urandom_range(0, 99) < 35);
      bus.clear_ovf = ($urandom_range(0, 99) < 5);
      tick("rand");
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
